// File: rtl/n64adv_ctrl_pkg.sv
// n64adv_ctrl_pkg: joybus command codes, receiver FSM states
// and the default in-game-reset button combo.
package n64adv_ctrl_pkg;

  localparam logic [7:0] CMD_POLL  = 8'h01;
  localparam logic [7:0] CMD_INFO  = 8'h00;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  // First received bit sits at bit 0: A,B,Z,Start,...,L(10),R(11).
  // Default combo is L+R+Z+Start.
  localparam logic [15:0] IGR_RESET = 16'h0C0C;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_CMD,
    ST_POLL,
    ST_STAT
  } rx_state_e;

  function automatic logic [5:0] resp_bits(rx_state_e s);
    return (s == ST_POLL) ? 6'd32 : 6'd24;
  endfunction

endpackage

// File: rtl/n64adv_ctrl_rx.sv
// n64adv_ctrl_rx: one joybus port (sync, edge history, wait counter,
// FSM, shift register). Ports: VCLK/nVRST, ctrl_i raw line, tick_i
// sample strobe; poll_done_o/abort_o events, data_o/status_o latched.
module n64adv_ctrl_rx
  import n64adv_ctrl_pkg::*;
#(
  parameter int WAIT_SAT = 255
) (
  input  logic        VCLK,
  input  logic        nVRST,
  input  logic        ctrl_i,
  input  logic        tick_i,
  output logic        poll_done_o,
  output logic        abort_o,
  output logic [31:0] data_o,
  output logic [23:0] status_o
);

  localparam logic [7:0] SAT = 8'(WAIT_SAT);

  logic [1:0]  sync_q;
  logic [2:0]  hist_q, hist_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  low_q, low_d;
  logic [5:0]  bcnt_q, bcnt_d;
  logic [31:0] sr_q, sr_d;
  logic [31:0] data_q, data_d;
  logic [23:0] stat_q, stat_d;
  rx_state_e   state_q, state_d;

  logic        neg, pos, sat, bit_v;
  logic [31:0] shl, shr;

  // Edges need two stable samples after the change.
  assign neg   = tick_i && (hist_q == 3'b100);
  assign pos   = tick_i && (hist_q == 3'b011);
  assign sat   = (wait_q == SAT);
  // High time longer than low time means a 1.
  assign bit_v = (low_q < wait_q);
  assign shl   = {sr_q[30:0], bit_v};
  assign shr   = {bit_v, sr_q[31:1]};

  always_comb begin
    hist_d = hist_q;
    wait_d = wait_q;
    low_d  = low_q;
    if (tick_i) begin
      hist_d = {hist_q[1:0], sync_q[1]};
      if (neg || pos) begin
        wait_d = '0;
      end else if (!sat) begin
        wait_d = wait_q + 8'd1;
      end
    end
    if (pos) begin
      low_d = wait_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    sr_d        = sr_q;
    data_d      = data_q;
    stat_d      = stat_q;
    poll_done_o = 1'b0;
    abort_o     = 1'b0;
    if (sat && (state_q != ST_WAIT)) begin
      state_d = ST_WAIT;
      abort_o = 1'b1;
    end else if (neg) begin
      unique case (state_q)
        ST_WAIT: begin
          if (sat) begin
            state_d = ST_CMD;
            bcnt_d  = '0;
            sr_d    = '0;
          end
        end
        ST_CMD: begin
          sr_d   = shl;
          bcnt_d = bcnt_q + 6'd1;
          if (bcnt_q == 6'd7) begin
            bcnt_d = '0;
            sr_d   = '0;
            unique case (1'b1)
              (shl[7:0] == CMD_POLL):
                state_d = ST_POLL;
              (shl[7:0] == CMD_INFO),
              (shl[7:0] == CMD_RESET):
                state_d = ST_STAT;
              default:
                state_d = ST_WAIT;
            endcase
          end
        end
        ST_POLL, ST_STAT: begin
          // Count 0 is the console stop bit, not data.
          if (bcnt_q != 6'd0) begin
            sr_d = shr;
          end
          bcnt_d = bcnt_q + 6'd1;
          if (bcnt_q == resp_bits(state_q)) begin
            state_d = ST_WAIT;
            if (state_q == ST_POLL) begin
              data_d      = shr;
              poll_done_o = 1'b1;
            end else begin
              stat_d = shr[31:8];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      sync_q  <= 2'b11;
      hist_q  <= 3'b111;
      wait_q  <= '0;
      low_q   <= '0;
      bcnt_q  <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      stat_q  <= '0;
      state_q <= ST_WAIT;
    end else begin
      sync_q  <= {sync_q[0], ctrl_i};
      hist_q  <= hist_d;
      wait_q  <= wait_d;
      low_q   <= low_d;
      bcnt_q  <= bcnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      stat_q  <= stat_d;
      state_q <= state_d;
    end
  end

  assign data_o   = data_q;
  assign status_o = stat_q;

endmodule

// File: rtl/n64adv_ctrl_sniffer.sv
// n64adv_ctrl_sniffer: multi-port joybus sniffer with frame-aligned
// valid/err flags and IGR trigger. Ports: VCLK/nVRST, CTRL lines,
// nVDSYNC/VD_VSi, use_igr; ctrl_data/status/valid/err, igr_req.
module n64adv_ctrl_sniffer
  import n64adv_ctrl_pkg::*;
#(
  parameter int          NUM_CH          = 1,
  parameter int          TICK_DIV        = 12,
  parameter int          WAIT_SAT        = 255,
  parameter int          IGR_CH          = 0,
  parameter logic [15:0] IGR_COMBO       = IGR_RESET,
  parameter int          IGR_HOLD_FRAMES = 8
) (
  input  logic                   VCLK,
  input  logic                   nVRST,
  input  logic [NUM_CH-1:0]      CTRL,
  input  logic                   nVDSYNC,
  input  logic                   VD_VSi,
  input  logic                   use_igr,
  output logic [32*NUM_CH-1:0]   ctrl_data,
  output logic [24*NUM_CH-1:0]   ctrl_status,
  output logic [NUM_CH-1:0]      ctrl_valid,
  output logic [NUM_CH-1:0]      ctrl_err,
  output logic                   igr_req
);

  localparam logic [5:0] TICK_LAST = 6'(TICK_DIV - 1);
  localparam logic [3:0] HOLD      = 4'(IGR_HOLD_FRAMES);

  logic [5:0]        tcnt_q, tcnt_d;
  logic              tick;
  logic [NUM_CH-1:0] poll_done, abort;
  logic [NUM_CH-1:0] valid_q, valid_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic              vs_q, vs_fall;
  logic [3:0]        cnt_q, cnt_d;
  logic              fired_q, fired_d;
  logic              igr_q, igr_d;
  logic              poll_seen_q;
  logic              match, hit;

  assign tick   = (tcnt_q == TICK_LAST);
  assign tcnt_d = tick ? 6'd0 : tcnt_q + 6'd1;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_rx
    n64adv_ctrl_rx #(
      .WAIT_SAT(WAIT_SAT)
    ) u_rx (
      .VCLK       (VCLK),
      .nVRST      (nVRST),
      .ctrl_i     (CTRL[i]),
      .tick_i     (tick),
      .poll_done_o(poll_done[i]),
      .abort_o    (abort[i]),
      .data_o     (ctrl_data[i*32 +: 32]),
      .status_o   (ctrl_status[i*24 +: 24])
    );
  end

  assign vs_fall = !nVDSYNC && vs_q && !VD_VSi;

  // A new event in the clearing cycle survives.
  assign valid_d = (vs_fall ? '0 : valid_q) | poll_done;
  assign err_d   = (vs_fall ? '0 : err_q) | abort;

  assign match = (ctrl_data[IGR_CH*32 +: 16] == IGR_COMBO);

  // fired blocks re-triggering until the combo is released.
  always_comb begin
    cnt_d   = cnt_q;
    fired_d = fired_q;
    igr_d   = 1'b0;
    if (!use_igr) begin
      cnt_d   = '0;
      fired_d = 1'b0;
    end else if (vs_fall) begin
      if (!match) begin
        cnt_d   = '0;
        fired_d = 1'b0;
      end else if (cnt_q != 4'hF) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    hit = (HOLD == 4'd0) ? poll_seen_q
                         : (vs_fall && (cnt_d == HOLD));
    if (use_igr && match && hit && !fired_q) begin
      igr_d   = 1'b1;
      fired_d = 1'b1;
    end
  end

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      tcnt_q      <= '0;
      valid_q     <= '0;
      err_q       <= '0;
      vs_q        <= 1'b0;
      cnt_q       <= '0;
      fired_q     <= 1'b0;
      igr_q       <= 1'b0;
      poll_seen_q <= 1'b0;
    end else begin
      tcnt_q      <= tcnt_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      if (!nVDSYNC) begin
        vs_q <= VD_VSi;
      end
      cnt_q       <= cnt_d;
      fired_q     <= fired_d;
      igr_q       <= igr_d;
      poll_seen_q <= poll_done[IGR_CH];
    end
  end

  assign ctrl_valid = valid_q;
  assign ctrl_err   = err_q;
  assign igr_req    = igr_q;

endmodule
